// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM states, FIFO entry
// layout and default FIFO depth.
package uart_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int DATA_W        = 9;
    localparam int ENTRY_W       = 11;
    localparam int FE_BIT        = 9;
    localparam int PE_BIT        = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_HOLD  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous receive FIFO with registered read port, occupancy counter and
// flush; a push is accepted while full when a pop happens in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LW    = $clog2(DEPTH) + 1,
    parameter int W     = ENTRY_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full,
    output logic          wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = rd_en && !empty && !flush;
    assign do_push = wr_en && (!full || do_pop) && !flush;
    assign wr_drop = wr_en && full && !do_pop && !flush;

    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are AW bits wide, so modulo-DEPTH wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: turns receiver data/error events into single FIFO
// pushes, pulses the receiver's sticky-flag clears, and raises irq.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    output logic              rx_enable,
    input  logic              rx_data_request,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_fe,
    input  logic              rx_pe,
    output logic              clear_fe,
    output logic              clear_pe,
    input  logic              rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LW-1:0]     level,
    output logic              empty,
    output logic              full,
    input  logic [LW-1:0]     threshold,
    output logic              overrun,
    input  logic              clear_overrun,
    output logic              irq,
    output rx_state_e         state_dbg
);

    rx_state_e          state;
    rx_state_e          next_state;
    logic               ev;
    logic               ev_q;
    logic               push_req;
    logic               wr_drop;
    logic [ENTRY_W-1:0] wr_entry;

    assign ev        = rx_data_request | rx_fe | rx_pe;
    assign state_dbg = state;

    always_comb begin
        wr_entry                 = '0;
        wr_entry[PE_BIT]         = rx_pe;
        wr_entry[FE_BIT]         = rx_fe;
        wr_entry[DATA_W-1:0]     = rx_data_request ? rx_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rx_enable <= 1'b0;
            ev_q      <= 1'b0;
            overrun   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= next_state;
            rx_enable <= en;
            ev_q      <= ev;
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
            irq <= overrun || ((threshold != '0) && (level >= threshold));
        end
    end

    // Clear pulses are gated by reset so a reset landing in CLEAR emits nothing.
    always_comb begin
        next_state = state;
        push_req   = 1'b0;
        clear_fe   = 1'b0;
        clear_pe   = 1'b0;
        if (!en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev && !ev_q) next_state = ST_PUSH;
                end
                ST_PUSH: begin
                    push_req   = 1'b1;
                    next_state = ST_CLEAR;
                end
                ST_CLEAR: begin
                    clear_fe   = rx_fe && reset;
                    clear_pe   = rx_pe && reset;
                    next_state = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!ev) next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Read handshake: rd_en is a request taken only when not empty; the popped
    // entry appears on rd_data with a one-cycle rd_valid pulse the next cycle.
    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr_en    (push_req),
        .wr_data  (wr_entry),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .wr_drop  (wr_drop)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed-plus-random bench for uart_rx_ctrl against a queue-based model of
// the receive FIFO, overrun flag and interrupt rule.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic              clk;
    logic              reset;
    logic              en;
    logic              flush;
    logic              rx_enable;
    logic              rx_data_request;
    logic [8:0]        rx_data;
    logic              rx_fe;
    logic              rx_pe;
    logic              clear_fe;
    logic              clear_pe;
    logic              rd_en;
    logic [10:0]       rd_data;
    logic              rd_valid;
    logic [LW-1:0]     level;
    logic              empty;
    logic              full;
    logic [LW-1:0]     threshold;
    logic              overrun;
    logic              clear_overrun;
    logic              irq;
    rx_state_e         state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    logic        model_ovr = 1'b0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .flush           (flush),
        .rx_enable       (rx_enable),
        .rx_data_request (rx_data_request),
        .rx_data         (rx_data),
        .rx_fe           (rx_fe),
        .rx_pe           (rx_pe),
        .clear_fe        (clear_fe),
        .clear_pe        (clear_pe),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .level           (level),
        .empty           (empty),
        .full            (full),
        .threshold       (threshold),
        .overrun         (overrun),
        .clear_overrun   (clear_overrun),
        .irq             (irq),
        .state_dbg       (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_enable"}, 32'(rx_enable), 32'(0));
        check({tag, "_level"},     32'(level),     32'(0));
        check({tag, "_empty"},     32'(empty),     32'(1));
        check({tag, "_full"},      32'(full),      32'(0));
        check({tag, "_overrun"},   32'(overrun),   32'(0));
        check({tag, "_irq"},       32'(irq),       32'(0));
        check({tag, "_rd_valid"},  32'(rd_valid),  32'(0));
        check({tag, "_rd_data"},   32'(rd_data),   32'(0));
        check({tag, "_clear_fe"},  32'(clear_fe),  32'(0));
        check({tag, "_clear_pe"},  32'(clear_pe),  32'(0));
        check({tag, "_state"},     32'(state_dbg), 32'(ST_IDLE));
    endtask

    task automatic check_status(input string tag);
        int  n = exp_q.size();
        logic exp_irq = model_ovr || ((threshold != 0) && (n >= int'(threshold)));
        @(negedge clk);
        check({tag, "_level"},   32'(level),   32'(n));
        check({tag, "_empty"},   32'(empty),   32'(n == 0));
        check({tag, "_full"},    32'(full),    32'(n == DEPTH));
        check({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
        check({tag, "_irq"},     32'(irq),     32'(exp_irq));
        @(posedge clk);
        #1;
    endtask

    // One receiver event held for `hold` cycles; records clear pulses and the
    // irq value on the cycle the level changes and on the cycle after.
    task automatic send_event(input logic req, input logic fe, input logic pe,
                              input logic [8:0] data, input int hold,
                              output int fe_n, output int pe_n,
                              output logic irq_at, output logic irq_after);
        logic [LW-1:0] lvl0 = level;
        bit  seen = 0;
        int  idx  = 0;
        fe_n = 0; pe_n = 0; irq_at = 1'b0; irq_after = 1'b0;
        rx_data_request = req; rx_fe = fe; rx_pe = pe; rx_data = data;
        for (int c = 0; c < hold + 5; c++) begin
            if (c == hold) begin
                rx_data_request = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
                rx_data = 9'($urandom_range(0, 511));
            end
            @(negedge clk);
            fe_n += int'(clear_fe);
            pe_n += int'(clear_pe);
            if (seen && c == idx + 1) irq_after = irq;
            if (!seen && level != lvl0) begin
                seen = 1; idx = c; irq_at = irq;
            end
            @(posedge clk);
            #1;
        end
        if (en) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({pe, fe, req ? data : 9'd0});
            else model_ovr = 1'b1;
        end
    endtask

    task automatic send_random(input string tag, input bit force_req);
        logic [2:0] p = 3'($urandom_range(1, 7));
        logic [8:0] d = 9'($urandom_range(0, 511));
        int fe_n, pe_n;
        logic ia, ib;
        if (force_req) p[0] = 1'b1;
        send_event(p[0], p[1], p[2], d, $urandom_range(4, 20), fe_n, pe_n, ia, ib);
        check({tag, "_clear_fe_cnt"}, 32'(fe_n), 32'(p[1]));
        check({tag, "_clear_pe_cnt"}, 32'(pe_n), 32'(p[2]));
    endtask

    task automatic pop_check(input string tag);
        logic [10:0] exp = exp_q.pop_front();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'(1));
        check({tag, "_rd_data"},  32'(rd_data),  32'(exp));
        @(negedge clk);
        check({tag, "_rd_valid_pulse"}, 32'(rd_valid), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fe_n, pe_n;
        logic ia, ib;
        logic [8:0] d;
        reset = 1'b0; en = 1'b0; flush = 1'b0; rd_en = 1'b0;
        rx_data_request = 1'b0; rx_data = '0; rx_fe = 1'b0; rx_pe = 1'b0;
        threshold = '0; clear_overrun = 1'b0;
        idle(3);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check("rx_enable_latency", 32'(rx_enable), 32'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rx_enable_on", 32'(rx_enable), 32'(1));
        @(posedge clk);
        #1;

        // Long data-ready level yields exactly one entry.
        send_event(1'b1, 1'b0, 1'b0, 9'h0A5, 40, fe_n, pe_n, ia, ib);
        check("data_clear_fe_cnt", 32'(fe_n), 32'(0));
        check("data_clear_pe_cnt", 32'(pe_n), 32'(0));
        check_status("data_push");
        pop_check("data_pop");

        // Framing error alone: data field forced to zero, one clear_fe pulse.
        send_event(1'b0, 1'b1, 1'b0, 9'($urandom_range(1, 511)), 4, fe_n, pe_n, ia, ib);
        check("fe_clear_fe_cnt", 32'(fe_n), 32'(1));
        check("fe_clear_pe_cnt", 32'(pe_n), 32'(0));
        check_status("fe_push");
        pop_check("fe_pop");

        for (int i = 0; i < 6; i++) send_random("rand", 1'b0);
        check_status("rand_fill");
        while (exp_q.size() > 0) pop_check("rand_pop");
        check_status("rand_drain");

        // Threshold interrupt, registered one cycle behind the level.
        threshold = LW'(4);
        for (int i = 0; i < 3; i++) send_random("thr", 1'b1);
        check_status("thr_below");
        d = 9'($urandom_range(0, 511));
        send_event(1'b1, 1'b0, 1'b0, d, 6, fe_n, pe_n, ia, ib);
        check("thr_irq_same_cycle", 32'(ia), 32'(0));
        check("thr_irq_next_cycle", 32'(ib), 32'(1));
        pop_check("thr_pop");
        idle(1);
        check_status("thr_after_pop");
        threshold = '0;
        while (exp_q.size() > 0) pop_check("thr_drain");

        // Overflow: seventeenth event is dropped and sets overrun.
        for (int i = 0; i < DEPTH + 1; i++) send_random("ovf", 1'b0);
        check_status("ovf_full");
        clear_overrun = 1'b1;
        model_ovr     = 1'b0;
        idle(1);
        clear_overrun = 1'b0;
        idle(1);
        check_status("ovf_cleared");

        // Full FIFO: pop in the push cycle lets the push through.
        d = 9'($urandom_range(0, 511));
        rx_data_request = 1'b1; rx_data = d;
        idle(1);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        @(negedge clk);
        check("simul_rd_valid", 32'(rd_valid), 32'(1));
        check("simul_rd_data",  32'(rd_data),  32'(exp_q.pop_front()));
        exp_q.push_back({2'b00, d});
        idle(4);
        rx_data_request = 1'b0;
        idle(4);
        check_status("simul");

        send_random("ovf2", 1'b0);
        check_status("ovf2");
        flush = 1'b1;
        rd_en = 1'b1;
        idle(1);
        flush = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_rd_valid", 32'(rd_valid), 32'(0));
        check("flush_level",    32'(level),    32'(0));
        check("flush_empty",    32'(empty),    32'(1));
        check("flush_overrun",  32'(overrun),  32'(1));
        @(posedge clk);
        #1;
        clear_overrun = 1'b1;
        model_ovr     = 1'b0;
        idle(1);
        clear_overrun = 1'b0;
        idle(1);

        // Read while empty is ignored.
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        @(negedge clk);
        check("empty_rd_valid", 32'(rd_valid), 32'(0));
        check("empty_rd_level", 32'(level),    32'(0));
        @(posedge clk);
        #1;

        // Disabled controller pushes nothing.
        en = 1'b0;
        idle(2);
        send_event(1'b1, 1'b1, 1'b0, 9'h155, 6, fe_n, pe_n, ia, ib);
        check("dis_rx_enable", 32'(rx_enable), 32'(0));
        check("dis_clear_fe",  32'(fe_n),      32'(0));
        check_status("dis");
        en = 1'b1;
        idle(2);

        // Reset landing in CLEAR aborts the clear pulse.
        rx_fe = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rstclr_clear_fe", 32'(clear_fe), 32'(0));
        check("rstclr_clear_pe", 32'(clear_pe), 32'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("rstclr");
        @(posedge clk);
        #1;
        rx_fe = 1'b0;
        reset = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, receive FIFO entry count (power of two, 4..64).
REQ-002 Parameter LW, default $clog2(DEPTH)+1, level-count width.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  controller enable; drives receiver enable.
REQ-006 flush  input  1  single-cycle pulse; empties FIFO.
REQ-007 rx_enable  output  1  enable to receiver.
REQ-008 rx_data_request  input  1  receiver data-ready level (holds for many clk cycles).
REQ-009 rx_data  input  9  receiver data word.
REQ-010 rx_fe, rx_pe  input  1 each  receiver sticky framing/parity error flags.
REQ-011 clear_fe, clear_pe  output  1 each  single-cycle clear pulses to receiver.
REQ-012 rd_en  input  1  consumer pop request.
REQ-013 rd_data  output  11  popped entry {pe, fe, data[8:0]}.
REQ-014 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-015 level  output  LW  current FIFO occupancy.
REQ-016 empty, full  output  1 each  FIFO status.
REQ-017 threshold  input  LW  irq occupancy threshold; 0 disables threshold irq.
REQ-018 overrun  output  1  sticky FIFO-overflow flag.
REQ-019 clear_overrun  input  1  clears overrun.
REQ-020 irq  output  1  interrupt request.

Function
REQ-021 rx_enable SHALL equal registered en (one-cycle latency).
REQ-022 FSM states SHALL be IDLE, PUSH, CLEAR, HOLD.
REQ-023 IDLE -> PUSH on rising edge of (rx_data_request OR rx_fe OR rx_pe), edge detected against previous-cycle registered value.
REQ-024 PUSH SHALL write {rx_pe, rx_fe, rx_data} into FIFO if not full, else drop entry and set overrun; data field written as 0 when rx_data_request is low; next state CLEAR.
REQ-025 CLEAR SHALL pulse clear_fe if rx_fe high and clear_pe if rx_pe high, one cycle each; next state HOLD.
REQ-026 HOLD SHALL return to IDLE only once rx_data_request, rx_fe and rx_pe are all low, guaranteeing one push per event.
REQ-027 rd_en with empty low SHALL pop; rd_data/rd_valid registered, valid the cycle after rd_en; rd_en when empty SHALL be ignored (no rd_valid, no pointer change).
REQ-028 Simultaneous push and pop SHALL leave level unchanged; pop-then-push allowed when full (push accepted if pop same cycle).
REQ-029 Pointers SHALL wrap modulo DEPTH; level range 0..DEPTH; full = (level == DEPTH), empty = (level == 0).
REQ-030 flush SHALL zero pointers and level next cycle; a same-cycle push or pop SHALL be discarded; overrun unaffected.
REQ-031 overrun set and clear_overrun in same cycle: set wins.
REQ-032 irq = overrun OR (threshold != 0 AND level >= threshold), registered.
REQ-033 en low SHALL force FSM to IDLE and suppress pushes; FIFO contents and reads unaffected.

Reset
REQ-034 On reset low: FSM IDLE, pointers/level 0, empty 1, full 0, overrun 0, irq 0, rd_valid 0, rd_data 0, clear_fe/clear_pe 0, rx_enable 0, edge register 0.
REQ-035 Reset mid-PUSH/CLEAR SHALL abort without a write or clear pulse.

Structure
REQ-036 Shared package uart_pkg SHALL hold the FSM state enum, the 11-bit entry field positions (PE_BIT=10, FE_BIT=9) and DEPTH default.
REQ-037 FIFO storage and pointers SHALL be a sub-module uart_sync_fifo; FSM and flags stay in uart_rx_ctrl.

Verification
REQ-038 rx_data_request high 40 cycles, rx_data=0x0A5 -> exactly one push, level=1, rd_en -> rd_data=0x0A5, rd_valid next cycle.
REQ-039 rx_fe pulse high with rx_data_request low -> entry 0x200 pushed, clear_fe pulsed once, clear_pe stays 0.
REQ-040 17 events with DEPTH=16 and no reads -> full=1, overrun=1, irq=1, level=16; clear_overrun -> overrun=0.
REQ-041 threshold=4, push 3 -> irq=0; 4th push -> irq=1 one cycle later; one rd_en -> irq=0.
REQ-042 full FIFO, push event and rd_en same cycle -> level stays 16, no overrun; then flush -> level=0, empty=1.
REQ-043 reset asserted during CLEAR -> no clear pulse, all outputs at REQ-034 values.
